// File: rtl/mem_access_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mem_access_unit_pkg                                              |
// | Purpose  : Shared widths, mem_sel size encodings, FSM state encoding and   |
// |            the alignment helper used by the MEM-stage access unit.         |
// | Contents : DATA_BUS, MEM_SEL_BUS, MEM_SEL_BYTE/HALF/WORD, state_t,         |
// |            is_misaligned()                                                 |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package mem_access_unit_pkg;

  localparam int DATA_BUS    = 32;
  localparam int MEM_SEL_BUS = 4;

  localparam logic [MEM_SEL_BUS-1:0] MEM_SEL_BYTE = 4'b0001;
  localparam logic [MEM_SEL_BUS-1:0] MEM_SEL_HALF = 4'b0011;
  localparam logic [MEM_SEL_BUS-1:0] MEM_SEL_WORD = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Halfwords need an even address, words a word-aligned one; bytes never fault.
  function automatic logic is_misaligned(input logic [MEM_SEL_BUS-1:0] sel,
                                         input logic [1:0]             offset);
    return ((sel == MEM_SEL_HALF) && offset[0]) ||
           ((sel == MEM_SEL_WORD) && (offset != 2'b00));
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mem_access_unit_if                                              |
// | Purpose  : Single-outstanding data-RAM handshake bundle.                   |
// | Signals  : ram_en          request, held until ram_ready                   |
// |            ram_write_en    byte-lane strobes, 0000 = read                  |
// |            ram_addr        word-aligned byte address                       |
// |            ram_write_data  lane-aligned store data                         |
// |            ram_read_data   read data, valid with ram_ready                 |
// |            ram_ready       single-cycle completion pulse                   |
// | Modports : master (access unit), slave (RAM)                               |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface mem_access_unit_if;
  import mem_access_unit_pkg::*;

  logic                   ram_en;
  logic [MEM_SEL_BUS-1:0] ram_write_en;
  logic [DATA_BUS-1:0]    ram_addr;
  logic [DATA_BUS-1:0]    ram_write_data;
  logic [DATA_BUS-1:0]    ram_read_data;
  logic                   ram_ready;

  modport master (
    output ram_en, ram_write_en, ram_addr, ram_write_data,
    input  ram_read_data, ram_ready
  );

  modport slave (
    input  ram_en, ram_write_en, ram_addr, ram_write_data,
    output ram_read_data, ram_ready
  );

endinterface
`default_nettype wire

// File: rtl/mem_access_unit_load_extend.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mem_access_unit_load_extend                                     |
// | Purpose  : Combinational load extraction: lane shift, size mask, extend.   |
// | Ports    : rdata  in  32  raw RAM word                                     |
// |            offset in  2   byte offset inside the word                      |
// |            sel    in  4   access size (byte/half/word)                     |
// |            sign   in  1   1 = sign-extend, 0 = zero-extend                 |
// |            data   out 32  extended result                                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module mem_access_unit_load_extend
  import mem_access_unit_pkg::*;
(
  input  wire logic [DATA_BUS-1:0]    rdata,
  input  wire logic [1:0]             offset,
  input  wire logic [MEM_SEL_BUS-1:0] sel,
  input  wire logic                   sign,
  output logic      [DATA_BUS-1:0]    data
);

  logic [DATA_BUS-1:0] w_shifted;

  always_comb begin
    w_shifted = rdata >> {offset, 3'b000};
    case (sel)
      MEM_SEL_BYTE: data = {{24{sign & w_shifted[7]}},  w_shifted[7:0]};
      MEM_SEL_HALF: data = {{16{sign & w_shifted[15]}}, w_shifted[15:0]};
      default:      data = w_shifted;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mem_access_unit                                                 |
// | Purpose  : MEM-stage responder. Issues one RAM access at a time, aligns    |
// |            store lanes, extracts/extends loads and stalls the pipeline     |
// |            until the access retires, aborts or faults on alignment.        |
// | Ports    : clk, rst_n (async, active low), flush                           |
// |            mem_read_flag / mem_write_flag / mem_sign_ext_flag / mem_sel    |
// |            mem_addr, mem_write_data          pipeline request              |
// |            ram                               RAM handshake (master)        |
// |            load_data                         extended load result          |
// |            done, align_error, bus_error      one-cycle status pulses       |
// |            stall_request                     hold the upstream pipeline    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  wire logic                   clk,
  input  wire logic                   rst_n,
  input  wire logic                   flush,
  input  wire logic                   mem_read_flag,
  input  wire logic                   mem_write_flag,
  input  wire logic                   mem_sign_ext_flag,
  input  wire logic [MEM_SEL_BUS-1:0] mem_sel,
  input  wire logic [DATA_BUS-1:0]    mem_addr,
  input  wire logic [DATA_BUS-1:0]    mem_write_data,
  mem_access_unit_if.master           ram,
  output logic      [DATA_BUS-1:0]    load_data,
  output logic                        done,
  output logic                        stall_request,
  output logic                        align_error,
  output logic                        bus_error
);

  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_ram_en;
  logic [MEM_SEL_BUS-1:0] r_ram_write_en;
  logic [DATA_BUS-1:0]    r_ram_addr;
  logic [DATA_BUS-1:0]    r_ram_write_data;
  logic [DATA_BUS-1:0]    r_load_data;
  logic                   r_done;
  logic                   r_align_error;
  logic                   r_bus_error;
  // Access attributes captured at acceptance; the pipeline inputs may change while BUSY.
  logic [1:0]             r_offset;
  logic [MEM_SEL_BUS-1:0] r_sel;
  logic                   r_sign;
  logic                   r_is_read;
  logic                   r_flushed;

  logic                   w_valid;
  logic                   w_misaligned;
  logic                   w_accept;
  logic                   w_align_hit;
  logic [MEM_SEL_BUS-1:0] w_strobe;
  logic [DATA_BUS-1:0]    w_store_data;
  logic [DATA_BUS-1:0]    w_load_ext;
  logic                   w_timeout;

  // A flush in IDLE blocks both acceptance and the alignment fault for that cycle.
  always_comb begin
    w_valid      = (mem_read_flag | mem_write_flag) && (mem_sel != '0);
    w_misaligned = is_misaligned(mem_sel, mem_addr[1:0]);
    w_accept     = (r_state == ST_IDLE) && w_valid && !w_misaligned && !flush;
    w_align_hit  = (r_state == ST_IDLE) && w_valid &&  w_misaligned && !flush;
    w_strobe     = mem_sel << mem_addr[1:0];
    w_store_data = mem_write_data << {mem_addr[1:0], 3'b000};
    w_timeout    = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  end

  mem_access_unit_load_extend u_load_extend (
    .rdata  (ram.ram_read_data),
    .offset (r_offset),
    .sel    (r_sel),
    .sign   (r_sign),
    .data   (w_load_ext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= ST_IDLE;
      r_cnt            <= '0;
      r_ram_en         <= 1'b0;
      r_ram_write_en   <= '0;
      r_ram_addr       <= '0;
      r_ram_write_data <= '0;
      r_load_data      <= '0;
      r_done           <= 1'b0;
      r_align_error    <= 1'b0;
      r_bus_error      <= 1'b0;
      r_offset         <= '0;
      r_sel            <= '0;
      r_sign           <= 1'b0;
      r_is_read        <= 1'b0;
      r_flushed        <= 1'b0;
    end else begin
      r_done        <= 1'b0;
      r_align_error <= 1'b0;
      r_bus_error   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_align_error <= w_align_hit;
          if (w_accept) begin
            r_state          <= ST_BUSY;
            r_cnt            <= '0;
            r_ram_en         <= 1'b1;
            r_ram_addr       <= {mem_addr[DATA_BUS-1:2], 2'b00};
            // Write wins when both flags are set.
            r_ram_write_en   <= mem_write_flag ? w_strobe : '0;
            r_ram_write_data <= mem_write_flag ? w_store_data : '0;
            r_is_read        <= !mem_write_flag;
            r_offset         <= mem_addr[1:0];
            r_sel            <= mem_sel;
            r_sign           <= mem_sign_ext_flag;
            r_flushed        <= 1'b0;
          end
        end
        ST_BUSY: begin
          // The RAM transaction always runs to completion; a flush only
          // suppresses the retirement side effects.
          if (flush) begin
            r_flushed <= 1'b1;
          end
          if (ram.ram_ready) begin
            r_state  <= ST_RESP;
            r_ram_en <= 1'b0;
            if (!(r_flushed || flush)) begin
              r_done <= 1'b1;
              if (r_is_read) begin
                r_load_data <= w_load_ext;
              end
            end
          end else if (w_timeout) begin
            r_state     <= ST_RESP;
            r_ram_en    <= 1'b0;
            r_bus_error <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          r_state        <= ST_IDLE;
          r_ram_write_en <= '0;
        end
        default: begin
          r_state  <= ST_IDLE;
          r_ram_en <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    ram.ram_en         = r_ram_en;
    ram.ram_write_en   = r_ram_write_en;
    ram.ram_addr       = r_ram_addr;
    ram.ram_write_data = r_ram_write_data;
    load_data          = r_load_data;
    done               = r_done;
    align_error        = r_align_error;
    bus_error          = r_bus_error;
    // RESP is excluded so the pipeline advances on the done cycle.
    stall_request      = w_accept || (r_state == ST_BUSY);
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_mem_access_unit                                              |
// | Purpose  : Scoreboard bench for mem_access_unit: directed accesses push    |
// |            expected retire events; a monitor pops and compares them.       |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        mem_read_flag = 1'b0;
  logic        mem_write_flag = 1'b0;
  logic        mem_sign_ext_flag = 1'b0;
  logic [3:0]  mem_sel = 4'b0;
  logic [31:0] mem_addr = 32'h0;
  logic [31:0] mem_write_data = 32'h0;
  logic [31:0] load_data;
  logic        done;
  logic        stall_request;
  logic        align_error;
  logic        bus_error;

  mem_access_unit_if ram_bus();

  mem_access_unit #(.TIMEOUT_CYCLES(64), .CNT_W(7)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .flush             (flush),
    .mem_read_flag     (mem_read_flag),
    .mem_write_flag    (mem_write_flag),
    .mem_sign_ext_flag (mem_sign_ext_flag),
    .mem_sel           (mem_sel),
    .mem_addr          (mem_addr),
    .mem_write_data    (mem_write_data),
    .ram               (ram_bus.master),
    .load_data         (load_data),
    .done              (done),
    .stall_request     (stall_request),
    .align_error       (align_error),
    .bus_error         (bus_error)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  // kind: 0 = done, 1 = align_error, 2 = bus_error
  typedef struct {
    int          kind;
    int          cyc;
    logic [31:0] ld;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_ld = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, want, cycle);
    end
  endtask

  task automatic push(input int kind, input int cyc, input logic [31:0] ld);
    exp_t e;
    e.kind = kind;
    e.cyc  = cyc;
    e.ld   = ld;
    sb.push_back(e);
  endtask

  // Monitor: every retire/fault pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && (done || align_error || bus_error)) begin
      int   k;
      exp_t e;
      k = done ? 0 : (align_error ? 1 : 2);
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_event: got kind=%0d at cycle %0d, want none", k, cycle);
      end else begin
        e = sb.pop_front();
        chk("event_kind", 32'(k), 32'(e.kind));
        chk("event_cycle", 32'(cycle), 32'(e.cyc));
        chk("event_load_data", load_data, e.ld);
      end
    end
  end

  task automatic clear_req();
    mem_read_flag     = 1'b0;
    mem_write_flag    = 1'b0;
    mem_sign_ext_flag = 1'b0;
    mem_sel           = 4'b0;
    mem_addr          = 32'h0;
    mem_write_data    = 32'h0;
  endtask

  // One access; ram_ready arrives in BUSY cycle rdy_dly+1. flush_at>0 raises
  // flush in that BUSY cycle and then no retirement is expected.
  task automatic access(input string nm, input bit rd, input bit wr, input bit sx,
                        input logic [3:0] sel, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rword,
                        input int rdy_dly, input int flush_at,
                        input logic [31:0] want_ld, input logic [31:0] want_ra,
                        input logic [3:0] want_we, input logic [31:0] want_wd);
    int r;
    int stalls;
    @(posedge clk); #1;
    mem_read_flag     = rd;
    mem_write_flag    = wr;
    mem_sign_ext_flag = sx;
    mem_sel           = sel;
    mem_addr          = addr;
    mem_write_data    = wdata;
    r = cycle;
    if (flush_at <= 0) begin
      if (rd && !wr) exp_ld = want_ld;
      push(0, r + 2 + rdy_dly, exp_ld);
    end
    #2;
    stalls = 0;
    if (stall_request) stalls++;
    for (int k = 1; k <= rdy_dly + 2; k++) begin
      @(posedge clk); #1;
      if (k == 1) clear_req();
      ram_bus.ram_ready     = (k == rdy_dly + 1);
      ram_bus.ram_read_data = (k == rdy_dly + 1) ? rword : 32'h5A5A5A5A;
      flush                 = (k == flush_at);
      #2;
      if (stall_request) stalls++;
      if (k <= rdy_dly + 1) begin
        chk({nm, "_ram_en"}, 32'(ram_bus.ram_en), 32'h1);
        chk({nm, "_ram_addr"}, ram_bus.ram_addr, want_ra);
        chk({nm, "_ram_write_en"}, 32'(ram_bus.ram_write_en), 32'(want_we));
        chk({nm, "_ram_write_data"}, ram_bus.ram_write_data, want_wd);
      end else begin
        chk({nm, "_ram_en_resp"}, 32'(ram_bus.ram_en), 32'h0);
      end
    end
    ram_bus.ram_ready = 1'b0;
    flush             = 1'b0;
    chk({nm, "_stall_cycles"}, 32'(stalls), 32'(rdy_dly + 2));
    chk({nm, "_load_data_after"}, load_data, exp_ld);
  endtask

  initial begin
    int r;
    ram_bus.ram_ready     = 1'b0;
    ram_bus.ram_read_data = 32'h0;
    repeat (2) @(posedge clk);
    #3;
    chk("reset_ram_en", 32'(ram_bus.ram_en), 32'h0);
    chk("reset_ram_write_en", 32'(ram_bus.ram_write_en), 32'h0);
    chk("reset_ram_addr", ram_bus.ram_addr, 32'h0);
    chk("reset_ram_write_data", ram_bus.ram_write_data, 32'h0);
    chk("reset_load_data", load_data, 32'h0);
    chk("reset_flags", {28'h0, done, stall_request, align_error, bus_error}, 32'h0);
    rst_n = 1'b1;

    access("lb",  1, 0, 1, MEM_SEL_BYTE, 32'h103, 32'h0, 32'h80AABBCC, 0, 0,
           32'hFFFFFF80, 32'h100, 4'b0000, 32'h0);
    access("lbu", 1, 0, 0, MEM_SEL_BYTE, 32'h103, 32'h0, 32'h80AABBCC, 0, 0,
           32'h00000080, 32'h100, 4'b0000, 32'h0);
    access("lh",  1, 0, 1, MEM_SEL_HALF, 32'h102, 32'h0, 32'h80017FFF, 0, 0,
           32'hFFFF8001, 32'h100, 4'b0000, 32'h0);
    access("lhu", 1, 0, 0, MEM_SEL_HALF, 32'h102, 32'h0, 32'h80017FFF, 0, 0,
           32'h00008001, 32'h100, 4'b0000, 32'h0);
    access("sb",  0, 1, 0, MEM_SEL_BYTE, 32'h201, 32'h000000A5, 32'h0, 0, 0,
           32'h0, 32'h200, 4'b0010, 32'h0000A500);
    access("sw",  0, 1, 0, MEM_SEL_WORD, 32'h200, 32'h12345678, 32'h0, 4, 0,
           32'h0, 32'h200, 4'b1111, 32'h12345678);
    access("lw",  1, 0, 0, MEM_SEL_WORD, 32'h10C, 32'h0, 32'hCAFEF00D, 1, 0,
           32'hCAFEF00D, 32'h10C, 4'b0000, 32'h0);

    // Misaligned word load: fault pulse next cycle, no RAM traffic, no stall.
    @(posedge clk); #1;
    mem_read_flag = 1'b1; mem_sel = MEM_SEL_WORD; mem_addr = 32'h202;
    r = cycle;
    push(1, r + 1, exp_ld);
    #2;
    chk("misalign_stall", 32'(stall_request), 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      clear_req();
      #2;
      chk("misalign_ram_en", 32'(ram_bus.ram_en), 32'h0);
    end

    // Flush in BUSY: RAM still completes, no done, load_data held.
    access("lw_flush", 1, 0, 0, MEM_SEL_WORD, 32'h108, 32'h0, 32'hDEADBEEF, 1, 1,
           32'h0, 32'h108, 4'b0000, 32'h0);

    // Flush in IDLE blocks acceptance.
    @(posedge clk); #1;
    mem_read_flag = 1'b1; mem_sel = MEM_SEL_WORD; mem_addr = 32'h10C; flush = 1'b1;
    #2;
    chk("idle_flush_stall", 32'(stall_request), 32'h0);
    @(posedge clk); #1;
    clear_req(); flush = 1'b0;
    #2;
    chk("idle_flush_ram_en", 32'(ram_bus.ram_en), 32'h0);

    // Timeout: 64 BUSY cycles then bus_error, load_data untouched.
    @(posedge clk); #1;
    mem_read_flag = 1'b1; mem_sel = MEM_SEL_WORD; mem_addr = 32'h104;
    r = cycle;
    push(2, r + 65, exp_ld);
    for (int k = 1; k <= 65; k++) begin
      @(posedge clk); #1;
      if (k == 1) clear_req();
      #2;
      if (k == 64) chk("timeout_ram_en_last_busy", 32'(ram_bus.ram_en), 32'h1);
      if (k == 65) chk("timeout_ram_en_resp", 32'(ram_bus.ram_en), 32'h0);
    end
    @(posedge clk); #3;
    chk("timeout_load_data", load_data, exp_ld);

    // Asynchronous reset in the middle of BUSY.
    @(posedge clk); #1;
    mem_read_flag = 1'b1; mem_sel = MEM_SEL_WORD; mem_addr = 32'h110;
    @(posedge clk); #1;
    clear_req();
    #1;
    chk("pre_reset_ram_en", 32'(ram_bus.ram_en), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_ram_en", 32'(ram_bus.ram_en), 32'h0);
    chk("async_reset_ram_addr", ram_bus.ram_addr, 32'h0);
    chk("async_reset_stall", 32'(stall_request), 32'h0);
    chk("async_reset_load_data", load_data, 32'h0);
    exp_ld = 32'h0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    access("lw_after_reset", 1, 0, 0, MEM_SEL_WORD, 32'h10C, 32'h0, 32'h13579BDF, 0, 0,
           32'h13579BDF, 32'h10C, 4'b0000, 32'h0);

    repeat (3) @(posedge clk);
    #3;
    chk("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
